// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Sequences the MEM stage against a variable-latency data memory using a
//   req/ack handshake. It holds the pipeline (StallM) until each load or store
//   completes. Load data returns to the MEM/WB register, and misaligned or
//   aborted accesses are flagged with a one-cycle error pulse.
//
//   Optional build macro: MEM_TIMEOUT_EN
//     When defined, a BUSY watchdog aborts an access after TIMEOUT cycles
//     without mem_ack.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   MemtoRegM     load in the MEM stage
//   MemWriteM     store in the MEM stage (wins if MemtoRegM is also set)
//   ALUOutM       byte address
//   WriteDataM    store data
//   mem_req       bus request (registered)
//   mem_we        bus write enable (registered)
//   mem_addr      bus address (registered)
//   mem_wdata     bus write data (registered)
//   mem_ack       bus completion, one cycle per request
//   mem_rdata     bus read data, valid with mem_ack
//   ReadDataM     captured load data (registered)
//   StallM        pipeline stall (combinational)
//   MemErrM       one-cycle error pulse (registered)
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              MemErrM
);

  // The watchdog compare needs TIMEOUT to be nonzero and to fit the counter.
  if (TIMEOUT < 1 || TIMEOUT >= (2 ** TO_W)) begin : g_to_range
    $error("mem_stage_ctrl: TIMEOUT must be nonzero and fit in TO_W bits");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nx;
  logic   access, aligned, to_hit;

  assign access  = MemtoRegM | MemWriteM;
  assign aligned = (ALUOutM[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
  // Counts BUSY cycles without ack. It is held at zero in IDLE, so it always
  // starts from zero on the first BUSY cycle. A hit on the cycle where the
  // count is TIMEOUT-1 aborts after exactly TIMEOUT BUSY cycles.
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           to_cnt <= '0;
    else if (state == IDLE)            to_cnt <= '0;
    else if (state == BUSY && !mem_ack) to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state == BUSY) && !mem_ack && (to_cnt == TO_W'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (access) state_nx = aligned ? BUSY : DONE;
      BUSY:    if (mem_ack || to_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic. StallM is released in DONE so that EX/MEM advances on that
  // edge. It is forced low while rst is asserted.
  always_comb begin
    StallM = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    StallM = access;
        BUSY:    StallM = 1'b1;
        default: StallM = 1'b0;
      endcase
    end
  end

  // Registered bus and result outputs. mem_we doubles as the load/store
  // marker while BUSY: it is latched from MemWriteM on issue, so !mem_we
  // means the pending access is a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
      MemErrM   <= 1'b0;
    end else begin
      MemErrM <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              mem_req   <= 1'b1;
              mem_we    <= MemWriteM;
              mem_addr  <= ALUOutM;
              mem_wdata <= WriteDataM;
            end else begin
              MemErrM   <= 1'b1;
              ReadDataM <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) ReadDataM <= mem_rdata;
          end else if (to_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            MemErrM   <= 1'b1;
            ReadDataM <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl. The bench plays the pipeline, holding
// each instruction until StallM drops. It also plays a memory that acks after
// a chosen number of wait cycles and sprays stray acks while idle.
// Expectations come from a per-instruction transaction model:
//   stall cycles  = 0 (no access), 1 (misaligned), or waits+2
//   request cycles = waits+1 for aligned accesses, 0 otherwise
//   ReadDataM and MemErrM are checked at the release cycle.
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM, MemErrM;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] rd_m;   // model of ReadDataM

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
    .StallM(StallM), .MemErrM(MemErrM)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction, starting #1 after a rising edge and ending #1 after
  // the edge on which EX/MEM advances.
  task automatic run_instr(input bit ld, input bit st, input logic [31:0] addr,
                           input logic [31:0] wd, input int waits,
                           input logic [31:0] rd);
    bit acc, algn, done;
    int exp_stall, stalls, req_cyc, cyc;
    logic [31:0] exp_rd;
    bit exp_err;

    acc       = ld | st;
    algn      = (addr % 4) == 0;
    exp_stall = !acc ? 0 : (!algn ? 1 : waits + 2);
    exp_err   = acc && !algn;
    exp_rd    = !acc ? rd_m : (!algn ? 32'h0 : (st ? rd_m : rd));

    MemtoRegM = ld; MemWriteM = st; ALUOutM = addr; WriteDataM = wd;
    stalls = 0; req_cyc = 0; cyc = 0; done = 0;
    while (!done) begin
      if (mem_req) begin
        mem_ack   = (req_cyc == waits);
        mem_rdata = (req_cyc == waits) ? rd : $urandom;
        req_cyc++;
      end else begin
        mem_ack   = ($urandom_range(0, 2) == 0);   // stray ack must be ignored
        mem_rdata = $urandom;
      end
      @(negedge clk);
      if (mem_req) begin
        chk("bus_addr", mem_addr, addr);
        chk("bus_we", mem_we, st);
        if (st) chk("bus_wdata", mem_wdata, wd);
      end else begin
        chk("we_idle", mem_we, 0);
      end
      if (StallM) stalls++;
      else begin
        done = 1;
        chk("stall_cycles", stalls, exp_stall);
        chk("req_cycles", req_cyc, (acc && algn) ? waits + 1 : 0);
        chk("readdata", ReadDataM, exp_rd);
        chk("memerr", MemErrM, exp_err);
      end
      cyc++;
      if (cyc > 64) begin
        chk("instr_timeout", 1, 0);
        done = 1;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    rd_m = exp_rd;
  endtask

  initial begin
    rst = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h10;
    WriteDataM = '0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; rd_m = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_err", MemErrM, 0);
    chk("rst_stall", StallM, 0);
    MemtoRegM = 1'b0; mem_ack = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the test plan
    run_instr(1, 0, 32'h10, 32'h0, 0, 32'hCAFE_F00D);
    run_instr(0, 1, 32'h20, 32'h1234_5678, 3, 32'h0);
    run_instr(1, 0, 32'h13, 32'h0, 0, 32'h0);
    run_instr(1, 0, 32'h04, 32'h0, 0, 32'h1111_2222);
    run_instr(1, 0, 32'h08, 32'h0, 0, 32'h3333_4444);
    run_instr(0, 0, 32'h55, 32'h0, 0, 32'h0);
    run_instr(1, 1, 32'h40, 32'hA5A5_A5A5, 1, 32'h0BAD_0BAD);

    // Reset in the second BUSY cycle, then a late ack
    MemtoRegM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h40;
    @(posedge clk); #1;
    chk("pre_rst_req", mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_stall", StallM, 0);
    chk("mid_rst_rdata", ReadDataM, 0);
    MemtoRegM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_ack_stall", StallM, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_rdata", ReadDataM, 0);
    chk("late_ack_err", MemErrM, 0);
    rd_m = '0;

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_instr(kind[0], kind[1], a, $urandom, $urandom_range(0, 5), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the MEM stage of the 5-stage pipeline against a variable-latency data memory using a req/ack handshake.
- Sits between the EX/MEM pipeline register outputs and the data-memory bus.
- Stalls the pipeline (PC, IF/ID, ID/EX, EX/MEM hold) until each load/store completes.
- Returns load data to the MEM/WB register and flags misaligned or failed accesses.

Parameters:
DATA_W, 32, data bus width
ADDR_W, 32, address width
TIMEOUT, 255, max BUSY cycles before abort (used only with MEM_TIMEOUT_EN)
TO_W, 8, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
MemtoRegM  in  1  load in MEM stage (from EX/MEM register)
MemWriteM  in  1  store in MEM stage (from EX/MEM register)
ALUOutM  in  ADDR_W  byte address from EX/MEM register
WriteDataM  in  DATA_W  store data from EX/MEM register
mem_req  out  1  bus request, registered
mem_we  out  1  bus write enable, registered
mem_addr  out  ADDR_W  bus address, registered
mem_wdata  out  DATA_W  bus write data, registered
mem_ack  in  1  bus completion, one cycle per request
mem_rdata  in  DATA_W  bus read data, valid with mem_ack
ReadDataM  out  DATA_W  captured load data, registered
StallM  out  1  pipeline stall, combinational from state and inputs
MemErrM  out  1  one-cycle error pulse, registered

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0, MemErrM=0.
  - StallM=0 while rst is asserted.
  - Reset mid-BUSY drops mem_req immediately; any late mem_ack is ignored.
- access = MemtoRegM | MemWriteM. Both high: treated as a store; ReadDataM is unchanged.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access=0: stay; StallM=0.
  - access=1, ALUOutM[1:0]==0: StallM=1. On the edge, latch mem_addr=ALUOutM, mem_wdata=WriteDataM, mem_we=MemWriteM; set mem_req=1; go BUSY.
  - access=1, ALUOutM[1:0]!=0: StallM=1; no request issued. On the edge, set MemErrM=1 and ReadDataM=0; go DONE.
- BUSY:
  - StallM=1; mem_req, mem_addr, mem_we and mem_wdata hold stable.
  - mem_ack=1: on the edge, mem_req=0 and mem_we=0. If it was a load, ReadDataM=mem_rdata. Go DONE.
  - mem_ack=0: stay in BUSY.
- DONE:
  - StallM=0, so EX/MEM advances at the end of this cycle.
  - MemErrM clears on the next edge. Always go IDLE (no reissue of the same instruction).
- Latency: a zero-wait memory (ack in the first BUSY cycle) gives 2 stall cycles; each extra wait cycle adds 1.
  - Minimum MEM occupancy is 3 cycles. Back-to-back memory ops pass through DONE→IDLE before the next is detected.
- mem_ack outside BUSY is ignored.
- ReadDataM holds its last value until the next load completes or an error occurs.
- Non-memory instructions never stall and see a 0-cycle controller overhead.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a TO_W-bit counter clears on IDLE→BUSY and increments each BUSY cycle without mem_ack.
  - If the counter reaches TIMEOUT with mem_ack=0: on the edge, mem_req=0, MemErrM=1, ReadDataM=0; go DONE.
  - mem_ack arriving in the same cycle as the timeout wins; the access completes normally.
- Undefined: no counter is built; BUSY waits indefinitely for mem_ack.

Test Plan:
- Load, addr 0x0000_0010, mem_ack in the first BUSY cycle, rdata 0xCAFE_F00D: mem_req high 1 cycle, StallM high 2 cycles, ReadDataM=0xCAFE_F00D in DONE, MemErrM=0.
- Store, addr 0x20, data 0x1234_5678, ack after 3 wait cycles: mem_we=1, mem_addr/mem_wdata stable throughout, StallM high 5 cycles, ReadDataM unchanged.
- Load at misaligned addr 0x0000_0013: mem_req never asserts, StallM high 1 cycle, MemErrM pulses 1 cycle, ReadDataM=0.
- Two consecutive loads (0x4 then 0x8, zero-wait): two separate requests with a DONE/IDLE gap; second ReadDataM correct; no duplicate request for the first.
- rst asserted in the second BUSY cycle, then ack one cycle later: mem_req=0 immediately, state IDLE, ack ignored, ReadDataM=0.
- MEM_TIMEOUT_EN with TIMEOUT=4, no ack: mem_req drops after 4 BUSY cycles, MemErrM=1 for 1 cycle, StallM releases in DONE.
